// File: rtl/alu.sv
// Registered integer ALU for the execute stage.
// Computes add/sub/and/or/slt/beq on zero-extended operands and registers the
// WIDTH+1 bit result plus a zero flag with one cycle of latency.
module alu #(
    parameter int unsigned WIDTH = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] SrcA,
    input  logic [WIDTH-1:0] SrcB,
    input  logic [2:0]       ALUControl,
    output logic             out_valid,
    output logic [WIDTH:0]   ALUResult,
    output logic             zero
);

    localparam logic [2:0] OpAdd = 3'b000;
    localparam logic [2:0] OpSub = 3'b001;
    localparam logic [2:0] OpAnd = 3'b010;
    localparam logic [2:0] OpOr  = 3'b011;
    localparam logic [2:0] OpSlt = 3'b100;
    localparam logic [2:0] OpBeq = 3'b101;

    logic [WIDTH:0] a;
    logic [WIDTH:0] b;
    logic           lt;
    logic [WIDTH:0] r;
    logic           z;

    logic [WIDTH:0] result_d, result_q;
    logic           zero_d, zero_q;
    logic           valid_d, valid_q;

    // Combinational next-result and next-zero for the current opcode.
    always_comb begin
        a  = {1'b0, SrcA};
        b  = {1'b0, SrcB};
        // Signed compare on the raw WIDTH-bit operands, not the extended ones.
        lt = $signed(SrcA) < $signed(SrcB);
        r  = '0;
        case (ALUControl)
            OpAdd:   r = a + b;
            OpSub:   r = a - b;
            OpAnd:   r = a & b;
            OpOr:    r = a | b;
            OpSlt:   r = {{WIDTH{1'b0}}, lt};
            OpBeq:   r = a - b;
            default: r = '0;
        endcase
        z = (r == '0);
    end

    // Capture a fresh result only when in_valid; otherwise hold and drop valid.
    always_comb begin
        result_d = result_q;
        zero_d   = zero_q;
        valid_d  = in_valid;
        if (in_valid) begin
            result_d = r;
            zero_d   = z;
        end
    end

    // Output registers with asynchronous clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            result_q <= '0;
            zero_q   <= 1'b0;
            valid_q  <= 1'b0;
        end else begin
            result_q <= result_d;
            zero_q   <= zero_d;
            valid_q  <= valid_d;
        end
    end

    assign ALUResult = result_q;
    assign zero      = zero_q;
    assign out_valid = valid_q;

endmodule

// File: tb/tb_alu.sv
// Scoreboard bench for alu (WIDTH=2): stimulus pushes hand-computed expectations,
// a negedge monitor pops and compares whenever out_valid is high.
module tb_alu;

    localparam int unsigned W = 2;

    logic           clk;
    logic           reset;
    logic           in_valid;
    logic [W-1:0]   SrcA;
    logic [W-1:0]   SrcB;
    logic [2:0]     ALUControl;
    logic           out_valid;
    logic [W:0]     ALUResult;
    logic           zero;

    typedef struct {
        logic [W:0] res;
        logic       z;
        string      name;
    } exp_t;

    exp_t sb[$];
    int   n_total = 0;
    int   n_pass  = 0;

    alu #(.WIDTH(W)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .SrcA      (SrcA),
        .SrcB      (SrcB),
        .ALUControl(ALUControl),
        .out_valid (out_valid),
        .ALUResult (ALUResult),
        .zero      (zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Drive one transaction at the negedge and record its expected response.
    task automatic issue(input string name, input logic [2:0] op, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic [W:0] res, input logic z);
        exp_t e;
        @(negedge clk);
        in_valid   = 1'b1;
        ALUControl = op;
        SrcA       = a;
        SrcB       = b;
        e.res  = res;
        e.z    = z;
        e.name = name;
        sb.push_back(e);
    endtask

    // Monitor: every presented result must match the oldest expectation.
    always @(negedge clk) begin
        if (!reset && out_valid) begin
            if (sb.size() == 0) begin
                n_total++;
                $display("FAIL unexpected_out_valid: got result %0h with empty scoreboard",
                         ALUResult);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check({e.name, "_res"}, 32'(ALUResult), 32'(e.res));
                check({e.name, "_zero"}, 32'(zero), 32'(e.z));
            end
        end
    end

    // Protocol guard: opcode must be known whenever in_valid is asserted.
    always @(posedge clk) begin
        if (!reset && in_valid === 1'b1 && $isunknown(ALUControl)) begin
            n_total++;
            $display("FAIL x_on_alucontrol: got %b expected known opcode", ALUControl);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W:0] last_res;
        logic       last_z;

        reset      = 1'b1;
        in_valid   = 1'b0;
        SrcA       = '0;
        SrcB       = '0;
        ALUControl = 3'b000;

        // Reset state, including a valid transaction presented under reset.
        #2;
        check("rst_res", 32'(ALUResult), 32'd0);
        check("rst_zero", 32'(zero), 32'd0);
        check("rst_valid", 32'(out_valid), 32'd0);
        in_valid = 1'b1;
        SrcA     = 2'b11;
        SrcB     = 2'b11;
        @(posedge clk);
        #1;
        check("rst_hold_res", 32'(ALUResult), 32'd0);
        check("rst_hold_zero", 32'(zero), 32'd0);
        check("rst_hold_valid", 32'(out_valid), 32'd0);
        @(negedge clk);
        in_valid = 1'b0;
        reset    = 1'b0;

        // Directed vectors, back-to-back.
        issue("add_01_01", 3'b000, 2'b01, 2'b01, 3'b010, 1'b0);
        issue("add_11_11", 3'b000, 2'b11, 2'b11, 3'b110, 1'b0);
        issue("add_10_10", 3'b000, 2'b10, 2'b10, 3'b100, 1'b0);
        issue("sub_10_01", 3'b001, 2'b10, 2'b01, 3'b001, 1'b0);
        issue("sub_01_10", 3'b001, 2'b01, 2'b10, 3'b111, 1'b0);
        issue("sub_10_10", 3'b001, 2'b10, 2'b10, 3'b000, 1'b1);
        issue("sub_00_11", 3'b001, 2'b00, 2'b11, 3'b101, 1'b0);
        issue("and_11_01", 3'b010, 2'b11, 2'b01, 3'b001, 1'b0);
        issue("or_10_01",  3'b011, 2'b10, 2'b01, 3'b011, 1'b0);
        issue("and_10_01", 3'b010, 2'b10, 2'b01, 3'b000, 1'b1);
        issue("slt_01_10", 3'b100, 2'b01, 2'b10, 3'b000, 1'b1);
        issue("slt_10_01", 3'b100, 2'b10, 2'b01, 3'b001, 1'b0);
        issue("slt_11_11", 3'b100, 2'b11, 2'b11, 3'b000, 1'b1);
        issue("beq_01_10", 3'b101, 2'b01, 2'b10, 3'b111, 1'b0);
        issue("beq_10_10", 3'b101, 2'b10, 2'b10, 3'b000, 1'b1);
        issue("rsv_110",   3'b110, 2'b11, 2'b01, 3'b000, 1'b1);
        issue("rsv_111",   3'b111, 2'b11, 2'b11, 3'b000, 1'b1);
        issue("add_10_01", 3'b000, 2'b10, 2'b01, 3'b011, 1'b0);
        last_res = 3'b011;
        last_z   = 1'b0;

        // Hold: in_valid low for three cycles while operands churn.
        @(negedge clk);
        in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            SrcA       = 2'(i);
            SrcB       = 2'(3 - i);
            ALUControl = 3'(i + 1);
            @(negedge clk);
            check("hold_valid", 32'(out_valid), 32'd0);
            check("hold_res", 32'(ALUResult), 32'(last_res));
            check("hold_zero", 32'(zero), 32'(last_z));
        end

        // Asynchronous reset between edges, right after a fresh result.
        in_valid   = 1'b1;
        ALUControl = 3'b000;
        SrcA       = 2'b11;
        SrcB       = 2'b01;
        @(posedge clk);
        #1;
        check("pre_rst_res", 32'(ALUResult), 32'b100);
        check("pre_rst_valid", 32'(out_valid), 32'd1);
        in_valid = 1'b0;
        #1;
        reset = 1'b1;
        #1;
        check("async_rst_res", 32'(ALUResult), 32'd0);
        check("async_rst_zero", 32'(zero), 32'd0);
        check("async_rst_valid", 32'(out_valid), 32'd0);
        @(negedge clk);
        reset = 1'b0;

        // Recovery after reset.
        issue("or_01_10", 3'b011, 2'b01, 2'b10, 3'b011, 1'b0);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("scoreboard_drained", 32'(sb.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
